// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory loader
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam int LEN_BYTES = 4;
    localparam int CSUM_W    = 8;

    // A load length is usable only if it is non-zero, word-aligned and fits the ROM.
    function automatic logic len_bad(input logic [31:0] len, input logic [31:0] rom_size);
        return (len == 32'd0) || (len[1:0] != 2'd0) || (len > rom_size);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs accepted program bytes into 32-bit words and strobes writes
module imem_word_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata
);

    logic [31:0] shreg;
    logic [1:0]  byte_cnt;
    logic [31:0] next_addr;
    logic [31:0] shreg_next;

    // Bytes enter at the top so the first byte of a group ends up in bits 7:0.
    assign shreg_next = {byte_data, shreg[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= 32'd0;
            byte_cnt  <= 2'd0;
            next_addr <= 32'd0;
            we        <= 1'b0;
            waddr     <= 32'd0;
            wdata     <= 32'd0;
        end else begin
            we <= 1'b0;
            if (clear) begin
                shreg     <= 32'd0;
                byte_cnt  <= 2'd0;
                next_addr <= 32'd0;
            end else if (byte_valid) begin
                shreg    <= shreg_next;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'(LEN_BYTES - 1)) begin
                    we        <= 1'b1;
                    wdata     <= shreg_next;
                    waddr     <= next_addr;
                    next_addr <= next_addr + 32'd4;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader with length header and 8-bit checksum
module imem_loader
    import imem_pkg::*;
#(
    parameter int ROM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_rst_n
);

    state_t              state;
    logic [1:0]          len_cnt;
    logic [31:0]         length;
    logic [31:0]         remain;
    logic [CSUM_W-1:0]   csum;
    logic                xfer;
    logic                can_start;
    logic [31:0]         len_next;

    assign xfer      = rx_valid && rx_ready;
    assign can_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign len_next  = {rx_data, length[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            len_cnt <= 2'd0;
            length  <= 32'd0;
            remain  <= 32'd0;
            csum    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (can_start) begin
                        state   <= ST_LEN;
                        len_cnt <= 2'd0;
                        length  <= 32'd0;
                        csum    <= '0;
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        length  <= len_next;
                        len_cnt <= len_cnt + 2'd1;
                        if (len_cnt == 2'(LEN_BYTES - 1)) begin
                            if (len_bad(len_next, 32'(ROM_SIZE))) begin
                                state <= ST_ERR;
                            end else begin
                                state  <= ST_DATA;
                                remain <= len_next;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum   <= csum + rx_data;
                        remain <= remain - 32'd1;
                        if (remain == 32'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        state <= (rx_data == csum) ? ST_DONE : ST_ERR;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (can_start),
        .byte_valid (xfer && (state == ST_DATA)),
        .byte_data  (rx_data),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    assign rx_ready  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign busy      = rx_ready;
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);
    assign cpu_rst_n = (state == ST_DONE);

endmodule
